// File: rtl/iob_sync_asym_fifo_ctl_pkg.sv
// Shared helpers and width-derivation functions for the asymmetric FIFO controller and its RAM.
package iob_sync_asym_fifo_ctl_pkg;

    function automatic int unsigned max_fn(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned min_fn(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    function automatic int unsigned clog2_fn(input int unsigned x);
        int unsigned r;
        r = 0;
        while ((1 << r) < x) r++;
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned x);
        return (x != 0) && ((x & (x - 1)) == 0);
    endfunction

    // Derived constants: MIN_W, MAX_W, WR and RR for a given write/read width pair.
    function automatic int unsigned min_w_of(input int unsigned w_w, input int unsigned r_w);
        return min_fn(w_w, r_w);
    endfunction

    function automatic int unsigned max_w_of(input int unsigned w_w, input int unsigned r_w);
        return max_fn(w_w, r_w);
    endfunction

    function automatic int unsigned wr_of(input int unsigned w_w, input int unsigned r_w);
        return w_w / min_fn(w_w, r_w);
    endfunction

    function automatic int unsigned rr_of(input int unsigned w_w, input int unsigned r_w);
        return r_w / min_fn(w_w, r_w);
    endfunction

endpackage

// File: rtl/iob_ram_2p_asym.sv
// Simple dual-port RAM of MIN_W-bit entries with asymmetric write/read ports and a
// registered read port; sub-word lane order is chosen by BIG_ENDIAN.
module iob_ram_2p_asym
    import iob_sync_asym_fifo_ctl_pkg::*;
#(
    parameter int unsigned W_DATA_W   = 32,
    parameter int unsigned R_DATA_W   = 8,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [R_DATA_W-1:0] r_data
);

    localparam int unsigned MIN_W = min_w_of(W_DATA_W, R_DATA_W);
    localparam int unsigned WR    = wr_of(W_DATA_W, R_DATA_W);
    localparam int unsigned RR    = rr_of(W_DATA_W, R_DATA_W);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [MIN_W-1:0]    mem [DEPTH];
    logic [R_DATA_W-1:0] r_word;

    // Bit offset of sub-word idx inside a word made of 'lanes' sub-words.
    function automatic int unsigned lane_pos(input int unsigned idx, input int unsigned lanes);
        return ((BIG_ENDIAN != 0) ? (lanes - 1 - idx) : idx) * MIN_W;
    endfunction

    // Pointers stay WR-aligned, so the address sum wraps cleanly within the array.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int unsigned i = 0; i < WR; i++) begin
                mem[w_addr + ADDR_W'(i)] <= w_data[lane_pos(i, WR) +: MIN_W];
            end
        end
    end

    always_comb begin
        r_word = '0;
        for (int unsigned i = 0; i < RR; i++) begin
            r_word[lane_pos(i, RR) +: MIN_W] = mem[r_addr + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= r_word;
        end
    end

endmodule

// File: rtl/iob_sync_asym_fifo_ctl.sv
// Single-clock asymmetric-width FIFO: pointers, occupancy, status flags and sticky error
// flags around an asymmetric dual-port RAM.
module iob_sync_asym_fifo_ctl
    import iob_sync_asym_fifo_ctl_pkg::*;
#(
    parameter int unsigned W_DATA_W   = 32,
    parameter int unsigned R_DATA_W   = 8,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned AFULL_TH   = (1 << ADDR_W) - 2 * wr_of(W_DATA_W, R_DATA_W),
    parameter int unsigned AEMPTY_TH  = 2 * rr_of(W_DATA_W, R_DATA_W),
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic                w_en,
    output logic                w_full,
    output logic                w_afull,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic                r_aempty,
    output logic [ADDR_W:0]     level,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned MIN_W = min_w_of(W_DATA_W, R_DATA_W);
    localparam int unsigned MAX_W = max_w_of(W_DATA_W, R_DATA_W);
    localparam int unsigned WR    = wr_of(W_DATA_W, R_DATA_W);
    localparam int unsigned RR    = rr_of(W_DATA_W, R_DATA_W);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0] DEPTH_LV  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] WR_LV     = (ADDR_W + 1)'(WR);
    localparam logic [ADDR_W:0] RR_LV     = (ADDR_W + 1)'(RR);
    localparam logic [ADDR_W:0] AFULL_LV  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LV = (ADDR_W + 1)'(AEMPTY_TH);

    if ((W_DATA_W % MIN_W != 0) || !is_pow2(W_DATA_W / MIN_W) ||
        (R_DATA_W % MIN_W != 0) || !is_pow2(R_DATA_W / MIN_W)) begin : g_bad_width
        $error("iob_sync_asym_fifo_ctl: widths must be MIN_W times a power of two");
    end
    if (ADDR_W < clog2_fn(MAX_W / MIN_W)) begin : g_bad_depth
        $error("iob_sync_asym_fifo_ctl: depth smaller than the wider port");
    end
    if ((AFULL_TH > DEPTH) || (AEMPTY_TH > DEPTH)) begin : g_bad_th
        $error("iob_sync_asym_fifo_ctl: thresholds exceed depth");
    end

    logic [ADDR_W-1:0] w_ptr_q, r_ptr_q;
    logic [ADDR_W:0]   level_q, level_d, free;
    logic              r_valid_q, overflow_q, underflow_q;
    logic              acc_w, acc_r;

    // Flags depend on the registered level only, so there is no same-cycle pass-through.
    always_comb begin
        free     = DEPTH_LV - level_q;
        w_full   = free < WR_LV;
        r_empty  = level_q < RR_LV;
        w_afull  = level_q >= AFULL_LV;
        r_aempty = level_q <= AEMPTY_LV;
        acc_w    = w_en & ~w_full & ~rst;
        acc_r    = r_en & ~r_empty & ~rst;
        level_d  = level_q;
        if (acc_w) level_d = level_d + WR_LV;
        if (acc_r) level_d = level_d - RR_LV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            r_valid_q   <= acc_r;
            overflow_q  <= overflow_q | (w_en & w_full);
            underflow_q <= underflow_q | (r_en & r_empty);
            if (acc_w) w_ptr_q <= w_ptr_q + ADDR_W'(WR);
            if (acc_r) r_ptr_q <= r_ptr_q + ADDR_W'(RR);
        end
    end

    iob_ram_2p_asym #(
        .W_DATA_W   (W_DATA_W),
        .R_DATA_W   (R_DATA_W),
        .ADDR_W     (ADDR_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .w_en   (acc_w),
        .w_addr (w_ptr_q),
        .w_data (w_data),
        .r_en   (acc_r),
        .r_addr (r_ptr_q),
        .r_data (r_data)
    );

    assign level     = level_q;
    assign r_valid   = r_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_iob_sync_asym_fifo_ctl.sv
// Directed bench: a 32->8 instance plus little- and big-endian 8->32 instances.
module tb_iob_sync_asym_fifo_ctl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32 -> 8, depth 16
    logic [31:0] a_w_data;
    logic        a_w_en, a_r_en;
    logic [7:0]  a_r_data;
    logic        a_r_valid, a_w_full, a_w_afull, a_r_empty, a_r_aempty, a_overflow, a_underflow;
    logic [4:0]  a_level;

    // 8 -> 32, depth 16, shared stimulus for both endian variants
    logic [7:0]  b_w_data;
    logic        b_w_en, b_r_en;
    logic [31:0] le_r_data, be_r_data;
    logic        le_r_valid, le_w_full, le_w_afull, le_r_empty, le_r_aempty, le_ovf, le_unf;
    logic        be_r_valid, be_w_full, be_w_afull, be_r_empty, be_r_aempty, be_ovf, be_unf;
    logic [4:0]  le_level, be_level;

    int n_tests = 0;
    int n_fail  = 0;

    iob_sync_asym_fifo_ctl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_dut_w2n (
        .clk(clk), .rst(rst), .w_data(a_w_data), .w_en(a_w_en), .w_full(a_w_full),
        .w_afull(a_w_afull), .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_r_valid),
        .r_empty(a_r_empty), .r_aempty(a_r_aempty), .level(a_level), .overflow(a_overflow),
        .underflow(a_underflow)
    );

    iob_sync_asym_fifo_ctl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .BIG_ENDIAN(0)) u_dut_le (
        .clk(clk), .rst(rst), .w_data(b_w_data), .w_en(b_w_en), .w_full(le_w_full),
        .w_afull(le_w_afull), .r_en(b_r_en), .r_data(le_r_data), .r_valid(le_r_valid),
        .r_empty(le_r_empty), .r_aempty(le_r_aempty), .level(le_level), .overflow(le_ovf),
        .underflow(le_unf)
    );

    iob_sync_asym_fifo_ctl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .BIG_ENDIAN(1)) u_dut_be (
        .clk(clk), .rst(rst), .w_data(b_w_data), .w_en(b_w_en), .w_full(be_w_full),
        .w_afull(be_w_afull), .r_en(b_r_en), .r_data(be_r_data), .r_valid(be_r_valid),
        .r_empty(be_r_empty), .r_aempty(be_r_aempty), .level(be_level), .overflow(be_ovf),
        .underflow(be_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_w_data = '0; a_w_en = 1'b0; a_r_en = 1'b0;
        b_w_data = '0; b_w_en = 1'b0; b_r_en = 1'b0;
        tick();
        tick();

        check("rst_level",    32'(a_level), 32'd0);
        check("rst_w_full",   32'(a_w_full), 32'd0);
        check("rst_w_afull",  32'(a_w_afull), 32'd0);
        check("rst_r_empty",  32'(a_r_empty), 32'd1);
        check("rst_r_aempty", 32'(a_r_aempty), 32'd1);
        check("rst_r_valid",  32'(a_r_valid), 32'd0);
        check("rst_r_data",   32'(a_r_data), 32'd0);
        check("rst_ovf",      32'(a_overflow), 32'd0);
        check("rst_unf",      32'(a_underflow), 32'd0);
        check("rst_le_empty", 32'(le_r_empty), 32'd1);
        rst = 1'b0;

        // One wide write, then four narrow reads in LSB-first order
        a_w_data = 32'h44332211; a_w_en = 1'b1;
        tick();
        a_w_en = 1'b0;
        check("wr1_level",   32'(a_level), 32'd4);
        check("wr1_r_empty", 32'(a_r_empty), 32'd0);
        check("wr1_aempty",  32'(a_r_aempty), 32'd0);
        a_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rd%0d_valid", i), 32'(a_r_valid), 32'd1);
            check($sformatf("rd%0d_data", i),  32'(a_r_data), 32'((i + 1) * 17));
            check($sformatf("rd%0d_level", i), 32'(a_level), 32'(3 - i));
        end

        // Read while empty
        tick();
        check("unf_valid", 32'(a_r_valid), 32'd0);
        check("unf_data",  32'(a_r_data), 32'h44);
        check("unf_flag",  32'(a_underflow), 32'd1);
        check("unf_level", 32'(a_level), 32'd0);
        a_r_en = 1'b0;
        tick();
        check("unf_sticky", 32'(a_underflow), 32'd1);

        // Fill to 16, then an overflowing fifth write
        a_w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_w_data = 32'hA3A2A1A0 + 32'(i) * 32'h10101010;
            tick();
            check($sformatf("fill%0d_level", i), 32'(a_level), 32'(4 * (i + 1)));
        end
        check("full_w_full",  32'(a_w_full), 32'd1);
        check("full_w_afull", 32'(a_w_afull), 32'd1);
        check("full_ovf0",    32'(a_overflow), 32'd0);
        a_w_data = 32'hEEEEEEEE;
        tick();
        a_w_en = 1'b0;
        check("ovf_level", 32'(a_level), 32'd16);
        check("ovf_flag",  32'(a_overflow), 32'd1);
        tick();
        check("ovf_sticky", 32'(a_overflow), 32'd1);

        // Drain eight entries; rejected write must not have clobbered data
        a_r_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("drain%0d_data", i), 32'(a_r_data),
                  32'(160 + 16 * (i / 4) + (i % 4)));
        end
        a_r_en = 1'b0;
        check("drain_level", 32'(a_level), 32'd8);
        check("drain_ovf",   32'(a_overflow), 32'd1);

        // Reset mid-operation with a write presented
        a_w_data = 32'h12345678; a_w_en = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; a_w_en = 1'b0;
        check("mrst_level",   32'(a_level), 32'd0);
        check("mrst_ovf",     32'(a_overflow), 32'd0);
        check("mrst_unf",     32'(a_underflow), 32'd0);
        check("mrst_r_empty", 32'(a_r_empty), 32'd1);
        tick();
        check("mrst_not_stored", 32'(a_level), 32'd0);

        // Pointers restart at zero after reset
        a_w_data = 32'h55667788; a_w_en = 1'b1;
        tick();
        a_w_en = 1'b0; a_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rd%0d", i), 32'(a_r_data), 32'(136 - 17 * i));
        end
        a_r_en = 1'b0;

        // Level 13: simultaneous write+read -> read accepted, write rejected
        a_w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_w_data = 32'h03020100 + 32'(i) * 32'h04040404;
            tick();
        end
        a_w_en = 1'b0; a_r_en = 1'b1;
        tick(); tick(); tick();
        check("l13_level", 32'(a_level), 32'd13);
        check("l13_ovf0",  32'(a_overflow), 32'd0);
        a_w_en = 1'b1; a_w_data = 32'hFFFFFFFF;
        tick();
        a_w_en = 1'b0; a_r_en = 1'b0;
        check("sim_level", 32'(a_level), 32'd12);
        check("sim_ovf",   32'(a_overflow), 32'd1);
        check("sim_valid", 32'(a_r_valid), 32'd1);
        check("sim_data",  32'(a_r_data), 32'h03);

        // Narrow-to-wide packing, both endian orders
        b_w_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_w_data = 8'(170 + 17 * i);
            tick();
            check($sformatf("n2w_le_empty%0d", i), 32'(le_r_empty), 32'd1);
            check($sformatf("n2w_be_empty%0d", i), 32'(be_r_empty), 32'd1);
        end
        b_w_data = 8'hDD;
        tick();
        b_w_en = 1'b0;
        check("n2w_le_ready", 32'(le_r_empty), 32'd0);
        check("n2w_be_ready", 32'(be_r_empty), 32'd0);
        check("n2w_le_level", 32'(le_level), 32'd4);
        b_r_en = 1'b1;
        tick();
        b_r_en = 1'b0;
        check("n2w_le_data",  le_r_data, 32'hDDCCBBAA);
        check("n2w_be_data",  be_r_data, 32'hAABBCCDD);
        check("n2w_le_valid", 32'(le_r_valid), 32'd1);
        check("n2w_le_level0", 32'(le_level), 32'd0);
        tick();
        check("n2w_valid_pulse", 32'(le_r_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_sync_asym_fifo_ctl.md
# iob_sync_asym_fifo_ctl

Single-clock FIFO with independent, asymmetric write and read widths, in either direction (wide-to-narrow or narrow-to-wide). It generalises the previous asymmetric FIFO with a fixed storage depth, programmable almost-full/almost-empty thresholds, an occupancy output, a registered read-valid strobe, sticky overflow/underflow error flags and a selectable sub-word order. It sits between width-mismatched producer/consumer datapaths, e.g. a 32-bit bus feeding a byte-serial engine, or the reverse.

## Interface
- W_DATA_W, 32, write word width; must be MIN_W·2^k
- R_DATA_W, 8, read word width; must be MIN_W·2^k
- ADDR_W, 6, depth = 2^ADDR_W entries of MIN_W = min(W_DATA_W, R_DATA_W) bits
- AFULL_TH, 2^ADDR_W − 2·(W_DATA_W/MIN_W), almost-full when level ≥ AFULL_TH
- AEMPTY_TH, 2·(R_DATA_W/MIN_W), almost-empty when level ≤ AEMPTY_TH
- BIG_ENDIAN, 0, 0: narrow sub-word 0 occupies the wide word's LSBs; 1: it occupies the MSBs
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- w_data  in  W_DATA_W  write data
- w_en  in  1  write request
- w_full  out  1  fewer than WR = W_DATA_W/MIN_W free entries
- w_afull  out  1  almost full
- r_en  in  1  read request
- r_data  out  R_DATA_W  read data, registered
- r_valid  out  1  r_data updated this cycle
- r_empty  out  1  fewer than RR = R_DATA_W/MIN_W entries held
- r_aempty  out  1  almost empty
- level  out  ADDR_W+1  occupancy in MIN_W units
- overflow  out  1  sticky: w_en asserted while w_full
- underflow  out  1  sticky: r_en asserted while r_empty

## Operation
- Storage holds 2^ADDR_W MIN_W-bit entries. The write pointer advances by WR per accepted write; the read pointer advances by RR per accepted read. Both pointers wrap modulo 2^ADDR_W.
- A write is accepted iff w_en & ~w_full. A read is accepted iff r_en & ~r_empty.
- Flags are decoded combinationally from the current `level` register only. A read in the same cycle does not unblock a write; a write in the same cycle does not unblock a read. There is no pass-through.
- Level update: level_next = level + WR·acc_w − RR·acc_r. The arithmetic is ADDR_W+1 bits wide. The result never exceeds 2^ADDR_W and never goes below 0.
- Sub-word order:
  - Wide-to-narrow: the wide word is split into sub-words, read in index order 0..RR−1.
  - Narrow-to-wide: sub-words are packed in index order.
  - BIG_ENDIAN selects the bit position of index 0, as defined in the parameter list.
- Rejected requests:
  - A rejected write leaves memory, pointers and level unchanged and sets overflow.
  - A rejected read leaves r_data unchanged, keeps r_valid = 0 and sets underflow.
  - overflow and underflow clear only on rst.
- Reset values: level 0, both pointers 0, r_data 0, r_valid 0, overflow 0, underflow 0. Consequently w_full = 0, r_empty = 1, r_aempty = 1 and w_afull = (AFULL_TH == 0).
- Reset asserted mid-operation discards all contents. Writes and reads presented in the same cycle as rst are ignored. Memory array contents are not cleared.

## Timing
- Write latency: data written at edge N is readable, with r_empty = 0, after edge N. This holds provided the level after edge N is ≥ RR.
- Read latency: for a read accepted at edge N, r_data and r_valid = 1 appear after edge N. r_valid is a single-cycle pulse per accepted read.
- Back-to-back accepted reads produce one r_data word per cycle.
- Flags and level change only on clock edges.

## Structure
- A shared header/package holds the max/min/clog2 helpers plus the derived constants MIN_W, MAX_W, WR and RR.
- Elaboration-time checks on parameters:
  - widths are MIN_W·power of two;
  - 2^ADDR_W ≥ max(WR, RR);
  - thresholds are ≤ 2^ADDR_W.
- One sub-module: iob_ram_2p_asym. It is an asymmetric simple dual-port RAM with a registered read port and internal sub-word lane selection. The controller (pointers, level, flags, error flags) stays in the top module.

## Test plan
- W=32, R=8, ADDR_W=4: reset, then write 0x44332211 → level = 4 and r_empty = 0 the next cycle. Four reads → r_data 0x11, 0x22, 0x33, 0x44, each with r_valid one cycle after the read.
- Same configuration: four writes → level = 16, w_full = 1. A fifth write → level stays 16, overflow = 1 and stays set until rst.
- Same configuration at level 13: assert w_en and r_en together → the read is accepted, the write is rejected, level = 12 and overflow = 1.
- W=8, R=32, BIG_ENDIAN=0: write 0xAA, 0xBB, 0xCC → r_empty stays 1. After the write of 0xDD → r_empty = 0. Read → r_data = 0xDDCCBBAA. Repeat with BIG_ENDIAN=1 → 0xAABBCCDD.
- Read while r_empty → r_valid = 0, r_data holds its previous value, underflow = 1.
- With the FIFO at level 8 and overflow set, pulse rst while w_en = 1 → level = 0, overflow = 0, r_empty = 1, and the write is not stored.
